dice_display_driver: RTL and testbench

//   Downstream consumer of the dice roller. Captures rolled_number a fixed delay after each roll

---
 rtl/dice_pkg.sv | 26 ++
 rtl/dice_display_driver_seg7.sv | 26 ++
 rtl/dice_display_driver.sv | 173 +++++++++++++++++
 tb/tb_dice_display_driver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice display driver: die selection,
// controller states, per-die face counts and special segment patterns.
package dice_pkg;

  typedef enum logic [1:0] {
    D4  = 2'b00,
    D6  = 2'b01,
    D8  = 2'b10,
    D20 = 2'b11
  } die_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CONVERT,
    SHOW
  } state_t;

  // Indexed by die_t; entry 0 is the d4.
  localparam logic [3:0][7:0] FACES = {8'd20, 8'd8, 8'd6, 8'd4};

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/dice_display_driver_seg7.sv
// Combinational BCD to seven-segment decoder, segments a..g on bits 0..6,
// active-high. Non-decimal codes decode to a blank digit.
module seg7_decoder
  import dice_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/dice_display_driver.sv
// Captures the rolled value, range-checks it, converts it to BCD by double-dabble
// and drives a multiplexed 2-digit display. LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module dice_display_driver
  import dice_pkg::*;
#(
  parameter int CAPTURE_DELAY = 2,
  parameter int REFRESH_BITS  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll,
  input  logic [1:0] die_select,
  input  logic [7:0] rolled_number,
  output logic [6:0] seg,
  output logic [1:0] digit_sel,
  output logic       busy,
  output logic       valid,
  output logic       range_err
);

  localparam int DW = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;
  localparam logic [DW-1:0] DELAY_LOAD = DW'(CAPTURE_DELAY - 1);

  state_t                  state_q, state_d;
  die_t                    die_q, die_d;
  logic [DW-1:0]           delay_q, delay_d;
  logic [2:0]              iter_q, iter_d;
  logic [7:0]              bin_q, bin_d;
  logic [11:0]             bcd_q, bcd_d;
  logic                    range_err_q, range_err_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic [3:0]              disp_tens_q, disp_tens_d;
  logic [3:0]              disp_ones_q, disp_ones_d;
  logic                    disp_dash_q, disp_dash_d;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [1:0]              digit_sel_q, digit_sel_d;
  logic [6:0]              seg_q, seg_d;

  logic [11:0] bcd_adj;
  logic [19:0] dd_shift;
  logic [3:0]  seg_nibble;
  logic [6:0]  dec_seg;

  // One double-dabble iteration: add 3 to any digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) begin
        bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
    end
    dd_shift = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d     = state_q;
    die_d       = die_q;
    delay_d     = delay_q;
    iter_d      = iter_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    range_err_d = range_err_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    disp_tens_d = disp_tens_q;
    disp_ones_d = disp_ones_q;
    disp_dash_d = disp_dash_q;
    case (state_q)
      IDLE, SHOW: begin
        if (roll) begin
          state_d = WAIT;
          die_d   = die_t'(die_select);
          delay_d = DELAY_LOAD;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (delay_q == '0) begin
          state_d     = CONVERT;
          bin_d       = rolled_number;
          bcd_d       = '0;
          iter_d      = '0;
          range_err_d = (rolled_number == 8'd0) || (rolled_number > FACES[die_q]);
        end else begin
          delay_d = delay_q - DW'(1);
        end
      end
      CONVERT: begin
        bcd_d  = dd_shift[19:8];
        bin_d  = dd_shift[7:0];
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = SHOW;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          // A nonzero hundreds digit means the value cannot fit on two digits.
          if (dd_shift[19:16] != 4'd0) begin
            disp_dash_d = 1'b1;
            disp_tens_d = BCD_BLANK;
            disp_ones_d = BCD_BLANK;
          end else begin
            disp_dash_d = 1'b0;
            disp_ones_d = dd_shift[11:8];
`ifdef LEADING_ZERO_BLANK_EN
            disp_tens_d = (dd_shift[15:12] == 4'd0) ? BCD_BLANK : dd_shift[15:12];
`else
            disp_tens_d = dd_shift[15:12];
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // seg is computed from the next digit select and next digit contents so the pair always agrees.
  always_comb begin
    refresh_d   = refresh_q + REFRESH_BITS'(1);
    digit_sel_d = (&refresh_q) ? ~digit_sel_q : digit_sel_q;
    seg_nibble  = digit_sel_d[1] ? disp_tens_d : disp_ones_d;
    seg_d       = disp_dash_d ? SEG_DASH : dec_seg;
  end

  seg7_decoder u_seg7 (
    .bcd (seg_nibble),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      die_q       <= D4;
      delay_q     <= '0;
      iter_q      <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      range_err_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      disp_tens_q <= BCD_BLANK;
      disp_ones_q <= BCD_BLANK;
      disp_dash_q <= 1'b0;
      refresh_q   <= '0;
      digit_sel_q <= 2'b01;
      seg_q       <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      die_q       <= die_d;
      delay_q     <= delay_d;
      iter_q      <= iter_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      range_err_q <= range_err_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      disp_tens_q <= disp_tens_d;
      disp_ones_q <= disp_ones_d;
      disp_dash_q <= disp_dash_d;
      refresh_q   <= refresh_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
    end
  end

  assign seg       = seg_q;
  assign digit_sel = digit_sel_q;
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_dice_display_driver.sv
// Self-checking bench for dice_display_driver: randomized rolls compared against a
// transaction-level model of capture timing, range check, decimal digits and refresh.
module tb_dice_display_driver;

  localparam int D  = 2;
  localparam int RB = 10;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       roll;
  logic [1:0] die_select;
  logic [7:0] rolled_number;
  logic [6:0] seg;
  logic [1:0] digit_sel;
  logic       busy;
  logic       valid;
  logic       range_err;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  logic       exp_busy, exp_valid, exp_err;
  logic [6:0] exp_tens, exp_ones;

  dice_display_driver #(
    .CAPTURE_DELAY (D),
    .REFRESH_BITS  (RB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .roll          (roll),
    .die_select    (die_select),
    .rolled_number (rolled_number),
    .seg           (seg),
    .digit_sel     (digit_sel),
    .busy          (busy),
    .valid         (valid),
    .range_err     (range_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0:       return 7'h3F;
      1:       return 7'h06;
      2:       return 7'h5B;
      3:       return 7'h4F;
      4:       return 7'h66;
      5:       return 7'h6D;
      6:       return 7'h7D;
      7:       return 7'h07;
      8:       return 7'h7F;
      9:       return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int facesOf(input logic [1:0] die);
    case (die)
      2'b00:   return 4;
      2'b01:   return 6;
      2'b10:   return 8;
      default: return 20;
    endcase
  endfunction

  task automatic setDisplay(input int v);
    if (v > 99) begin
      exp_tens = 7'h40;
      exp_ones = 7'h40;
    end else begin
      exp_ones = segOf(v % 10);
      exp_tens = (LZB && (v / 10) == 0) ? 7'h00 : segOf(v / 10);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic checkState(input string tag);
    logic [1:0] exp_sel;
    exp_sel = (((edge_n >> RB) & 1) != 0) ? 2'b10 : 2'b01;
    checkOutput({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    checkOutput({tag, ".valid"}, 32'(valid), 32'(exp_valid));
    checkOutput({tag, ".range_err"}, 32'(range_err), 32'(exp_err));
    checkOutput({tag, ".digit_sel"}, 32'(digit_sel), 32'(exp_sel));
    checkOutput({tag, ".seg"}, 32'(seg), 32'((exp_sel == 2'b10) ? exp_tens : exp_ones));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic modelReset();
    exp_busy  = 1'b0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_tens  = 7'h00;
    exp_ones  = 7'h00;
    edge_n    = 0;
  endtask

  task automatic doReset();
    #2 reset = 1'b1;
    roll = 1'b0;
    #1;
    modelReset();
    checkState("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkState("after_reset");
  endtask

  task automatic idle(input int n);
    roll = 1'b0;
    for (int c = 0; c < n; c++) begin
      tick();
      checkState("idle");
    end
  endtask

  // noisy: 0 = no extra rolls, 1 = one extra roll while waiting, 2 = random extra rolls
  task automatic applyStimulus(input logic [1:0] die, input logic [7:0] value,
                               input int noisy, input bit hold, input int abort_at);
    roll          = 1'b1;
    die_select    = die;
    rolled_number = 8'($urandom);
    tick();
    exp_busy  = 1'b1;
    exp_valid = 1'b0;
    checkState("roll");
    for (int i = 1; i <= D + 8; i++) begin
      if (i == abort_at) begin
        doReset();
        return;
      end
      roll = hold || (noisy == 1 && i == 1) || (noisy == 2 && $urandom_range(0, 2) == 0);
      die_select    = 2'($urandom);
      rolled_number = (i == D) ? value : (value ^ 8'($urandom_range(1, 255)));
      tick();
      if (i == D) exp_err = (value == 8'd0) || (int'(value) > facesOf(die));
      if (i == D + 8) begin
        exp_busy  = 1'b0;
        exp_valid = 1'b1;
        setDisplay(int'(value));
      end
      checkState($sformatf("roll_v%0d_c%0d", value, i));
    end
    roll = hold;
  endtask

  initial begin
    logic [1:0] rdie;
    logic [7:0] rval;
    reset         = 1'b1;
    roll          = 1'b0;
    die_select    = 2'b00;
    rolled_number = 8'd0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkState("reset");
    reset = 1'b0;
    idle(3);

    applyStimulus(2'b11, 8'd42, 0, 1'b0, D + 4);
    idle(2);
    applyStimulus(2'b11, 8'd17, 0, 1'b0, -1);
    idle(1030);
    applyStimulus(2'b01, 8'd0, 0, 1'b0, -1);
    idle(4);
    applyStimulus(2'b00, 8'd5, 0, 1'b0, -1);
    idle(4);
    applyStimulus(2'b10, 8'd8, 0, 1'b0, -1);
    idle(4);
    applyStimulus(2'b11, 8'd200, 0, 1'b0, -1);
    idle(1030);
    applyStimulus(2'b00, 8'd3, 0, 1'b0, -1);
    idle(1030);
    applyStimulus(2'b11, 8'd9, 1, 1'b0, -1);
    idle(3);
    applyStimulus(2'b10, 8'd6, 0, 1'b1, -1);
    applyStimulus(2'b01, 8'd99, 0, 1'b1, -1);
    applyStimulus(2'b11, 8'd100, 0, 1'b0, -1);
    idle(5);

    for (int r = 0; r < 20; r++) begin
      rdie = 2'($urandom);
      rval = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 25)) : 8'($urandom_range(0, 255));
      applyStimulus(rdie, rval, 2, 1'b0, -1);
      idle($urandom_range(0, 40));
    end
    idle(1100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
